// File: rtl/mem_block_responder_if.sv
// Cache-to-memory block load/store bus. D_WIDTH and WIDTH_AD must match
// the parameters of the mem_block_responder instance that binds to it.
interface mem_block_responder_if #(
    parameter int D_WIDTH  = 32,
    parameter int WIDTH_AD = 16
);
    logic [WIDTH_AD-1:0] address_in;
    logic [D_WIDTH-1:0]  data_in;
    logic                load_req;
    logic                store_req;
    logic                load_ack;
    logic                store_ack;
    logic [D_WIDTH-1:0]  data_out;
    logic                load_completed;
    logic                store_completed;
    logic                busy;
    logic                err;

    modport master (
        output address_in, data_in, load_req, store_req, load_ack, store_ack,
        input  data_out, load_completed, store_completed, busy, err
    );

    modport slave (
        input  address_in, data_in, load_req, store_req, load_ack, store_ack,
        output data_out, load_completed, store_completed, busy, err
    );
endinterface

// File: rtl/mem_block_responder.sv
// Fixed-latency memory responder for the cache block load/store handshake.
// Optional macro MEM_ERR_CHECK_EN adds a sticky alignment/range/collision error flag.
module mem_block_responder #(
    parameter int D_WIDTH    = 32,
    parameter int WIDTH_AD   = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_block_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_DONE    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [D_WIDTH-1:0]    wdata_q, wdata_d;
    logic                  is_store_q, is_store_d;
    logic [D_WIDTH-1:0]    data_out_q, data_out_d;
    logic                  load_cmp_q, load_cmp_d;
    logic                  store_cmp_q, store_cmp_d;
    logic                  busy_q, busy_d;
    logic                  mem_we_s;
    logic                  req_s;
    logic                  accept_s;
    logic                  ack_s;

    logic [D_WIDTH-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];

    assign req_s    = bus.load_req | bus.store_req;
    assign accept_s = (state_q == S_IDLE) && req_s;
    assign ack_s    = is_store_q ? bus.store_ack : bus.load_ack;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= '0;
            is_store_q  <= 1'b0;
            data_out_q  <= '0;
            load_cmp_q  <= 1'b0;
            store_cmp_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            is_store_q  <= is_store_d;
            data_out_q  <= data_out_d;
            load_cmp_q  <= load_cmp_d;
            store_cmp_q <= store_cmp_d;
            busy_q      <= busy_d;
        end
    end

    // Block array; write enable is derived from the reset-cleared state, so a reset discards a pending store.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        is_store_d  = is_store_q;
        data_out_d  = data_out_q;
        load_cmp_d  = load_cmp_q;
        store_cmp_d = store_cmp_q;
        mem_we_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    idx_d      = bus.address_in[DEPTH_LOG2+1:2];
                    wdata_d    = bus.data_in;
                    is_store_d = bus.store_req;
                    cnt_d      = 4'(LATENCY - 1);
                    state_d    = S_BUSY;
                end else begin
                    state_d    = S_IDLE;
                end
            end
            S_BUSY: begin
                if (cnt_q == 4'd0) begin
                    if (is_store_q) begin
                        mem_we_s    = 1'b1;
                        store_cmp_d = 1'b1;
                    end else begin
                        data_out_d  = mem_q[idx_q];
                        load_cmp_d  = 1'b1;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (ack_s) begin
                    load_cmp_d  = 1'b0;
                    store_cmp_d = 1'b0;
                    state_d     = S_RELEASE;
                end else begin
                    state_d     = S_DONE;
                end
            end
            S_RELEASE: begin
                // Hold here until the cache lets go, so a held request cannot retrigger.
                if (!req_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign bus.data_out        = data_out_q;
    assign bus.load_completed  = load_cmp_q;
    assign bus.store_completed = store_cmp_q;
    assign bus.busy            = busy_q;

`ifdef MEM_ERR_CHECK_EN
    logic err_q, err_d;
    logic bad_req_s;

    assign bad_req_s = (bus.address_in[1:0] != 2'b00)
                     | (|bus.address_in[WIDTH_AD-1:DEPTH_LOG2+2])
                     | (bus.load_req & bus.store_req);

    // Sticky protocol error, evaluated only at accept.
    always_comb begin
        if (accept_s && bad_req_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    logic unused_s;
    assign unused_s = ^{accept_s, bus.address_in[WIDTH_AD-1:DEPTH_LOG2+2], bus.address_in[1:0]};
    assign bus.err  = 1'b0;
`endif
endmodule

// File: tb/tb_mem_block_responder.sv
// Randomized self-checking bench for mem_block_responder against a
// transaction-level model (array of blocks plus sticky error rule).
module tb_mem_block_responder;
    localparam int LAT = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] model_mem [0:255];
    bit          model_valid [0:255];
    logic [31:0] exp_dout;
    bit          dout_known;
    bit          exp_err;

    mem_block_responder_if #(.D_WIDTH(32), .WIDTH_AD(16)) bus ();

    mem_block_responder #(
        .D_WIDTH(32), .WIDTH_AD(16), .DEPTH_LOG2(8), .LATENCY(LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check_val({tag, "_flags"}, {30'd0, bus.load_completed, bus.store_completed}, 32'd0);
        check_val({tag, "_err"}, {31'd0, bus.err}, {31'd0, exp_err});
        if (dout_known) check_val({tag, "_dout"}, bus.data_out, exp_dout);
    endtask

    // One transaction; time on entry/exit is #1 after a rising edge, DUT in IDLE.
    task automatic do_op(input bit st, input bit both, input logic [15:0] addr,
                         input logic [31:0] data, input int hold, input bit hold_req);
        logic [7:0] idx;
        bit         is_st;
        idx   = addr[9:2];
        is_st = st | both;
        bus.address_in = addr;
        bus.data_in    = data;
        bus.store_req  = st | both;
        bus.load_req   = ~st | both;
        @(posedge clk); #1;
        check_val("busy_at_accept", {31'd0, bus.busy}, 32'd1);
`ifdef MEM_ERR_CHECK_EN
        if (addr[1:0] != 2'b00 || addr[15:10] != 6'd0 || both) exp_err = 1'b1;
`endif
        if (!hold_req) begin
            bus.load_req   = 1'b0;
            bus.store_req  = 1'b0;
            bus.address_in = 16'($urandom);
            bus.data_in    = $urandom;
        end
        repeat (LAT - 1) begin
            @(posedge clk); #1;
            check_val("early_flag", {30'd0, bus.load_completed, bus.store_completed}, 32'd0);
        end
        @(posedge clk); #1;
        if (is_st) begin
            model_mem[idx]   = data;
            model_valid[idx] = 1'b1;
            check_val("store_done", {30'd0, bus.load_completed, bus.store_completed}, 32'd1);
        end else begin
            check_val("load_done", {30'd0, bus.load_completed, bus.store_completed}, 32'd2);
            dout_known = model_valid[idx];
            exp_dout   = model_mem[idx];
        end
        if (dout_known) check_val("dout_at_done", bus.data_out, exp_dout);
        for (int h = 0; h < hold; h++) begin
            if (is_st) bus.load_ack = 1'($urandom);
            else       bus.store_ack = 1'($urandom);
            @(posedge clk); #1;
            bus.load_ack  = 1'b0;
            bus.store_ack = 1'b0;
            check_val("hold_flags", {30'd0, bus.load_completed, bus.store_completed},
                      is_st ? 32'd1 : 32'd2);
            if (dout_known) check_val("hold_dout", bus.data_out, exp_dout);
        end
        if (is_st) bus.store_ack = 1'b1;
        else       bus.load_ack = 1'b1;
        @(posedge clk); #1;
        bus.load_ack  = 1'b0;
        bus.store_ack = 1'b0;
        check_val("flag_cleared", {30'd0, bus.load_completed, bus.store_completed}, 32'd0);
        check_val("busy_release", {31'd0, bus.busy}, 32'd1);
        if (hold_req) begin
            repeat (4) begin
                @(posedge clk); #1;
                check_val("held_req_busy", {31'd0, bus.busy}, 32'd1);
                check_val("held_req_flags", {30'd0, bus.load_completed, bus.store_completed}, 32'd0);
            end
            bus.load_req  = 1'b0;
            bus.store_req = 1'b0;
        end
        @(posedge clk); #1;
        check_idle_outputs("back_idle");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        exp_err    = 1'b0;
        exp_dout   = 32'd0;
        dout_known = 1'b1;
        for (int i = 0; i < 256; i++) begin
            model_mem[i]   = 32'd0;
            model_valid[i] = 1'b0;
        end
        bus.address_in = 16'd0;
        bus.data_in    = 32'd0;
        bus.load_req   = 1'b0;
        bus.store_req  = 1'b0;
        bus.load_ack   = 1'b0;
        bus.store_ack  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset");

        // Store then load of the same block.
        do_op(1'b1, 1'b0, 16'h0004, 32'hDEAD0100, 0, 1'b0);
        do_op(1'b0, 1'b0, 16'h0004, 32'h0, 0, 1'b0);
        check_val("store_load_data", bus.data_out, 32'hDEAD0100);

        // Completion held for 10 cycles with the wrong ack toggling.
        do_op(1'b0, 1'b0, 16'h0004, 32'h0, 10, 1'b0);

        // Store request held past the ack; only one write, then re-read.
        do_op(1'b1, 1'b0, 16'h0020, 32'hCAFEF00D, 2, 1'b1);
        do_op(1'b0, 1'b0, 16'h0020, 32'h0, 0, 1'b0);

        // Reset during the second BUSY cycle of a store over a known zero.
        do_op(1'b1, 1'b0, 16'h0010, 32'h00000000, 0, 1'b0);
        bus.address_in = 16'h0010;
        bus.data_in    = 32'h12345678;
        bus.store_req  = 1'b1;
        @(posedge clk); #1;
        bus.store_req  = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        exp_err    = 1'b0;
        exp_dout   = 32'd0;
        dout_known = 1'b1;
        check_idle_outputs("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("after_reset");
        do_op(1'b0, 1'b0, 16'h0010, 32'h0, 0, 1'b0);
        check_val("reset_discards_store", bus.data_out, 32'h00000000);

        // Simultaneous requests: store wins.
        do_op(1'b0, 1'b1, 16'h0008, 32'hA5A5A5A5, 0, 1'b0);
        do_op(1'b0, 1'b0, 16'h0008, 32'h0, 0, 1'b0);
        check_val("both_req_store", bus.data_out, 32'hA5A5A5A5);

        // Out-of-range address aliases onto block 1.
        do_op(1'b1, 1'b0, 16'h0404, 32'h0BADBEEF, 0, 1'b0);
        do_op(1'b0, 1'b0, 16'h0004, 32'h0, 0, 1'b0);
        check_val("alias_data", bus.data_out, 32'h0BADBEEF);

        // Random traffic over a small set of blocks so loads hit written data.
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            a = 16'($urandom);
            a[9:2] = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                a[15:10] = 6'd0;
                a[1:0]   = 2'd0;
            end
            do_op(1'($urandom), ($urandom_range(0, 9) == 0), a, $urandom,
                  $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_block_responder.md
# mem_block_responder

Memory-side responder for the cache's block load/store protocol. Accepts one 32-bit block request at a time from the cache, applies a fixed access latency, and performs the request against an internal block array. It then holds its completion flag until the cache acknowledges. It replaces the bare RAM model between the cache and the rest of the pipeline.

## Interface

Parameters:
- D_WIDTH, 32, block width in bits; one cache block per memory word
- WIDTH_AD, 16, byte-address width of address_in
- DEPTH_LOG2, 8, log2 of the number of block words stored (256 blocks)
- LATENCY, 3, cycles from accept to completion; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- address_in  in  WIDTH_AD  byte address of block; block index = address_in[DEPTH_LOG2+1:2]
- data_in  in  D_WIDTH  block to store
- load_req  in  1  cache requests block load
- store_req  in  1  cache requests block store
- load_ack  in  1  cache has consumed data_out
- store_ack  in  1  cache has seen store_completed
- data_out  out  D_WIDTH  loaded block, valid while load_completed high
- load_completed  out  1  load data ready
- store_completed  out  1  store written to array
- busy  out  1  high in any state except IDLE
- err  out  1  sticky protocol error (see Configuration)

## Operation

- FSM states: IDLE, BUSY, DONE, RELEASE.
- IDLE:
  - Samples load_req/store_req.
  - If either is high, latches address_in, data_in and op type (store wins if both high).
  - Loads the counter with LATENCY-1 and goes to BUSY.
- BUSY:
  - Counter decrements each cycle.
  - When the counter reads 0: a store writes mem[index] <= latched data and sets store_completed; a load sets data_out <= mem[index] and load_completed. The state then goes to DONE.
  - Requests dropped during BUSY do not abort the operation.
- DONE:
  - The completion flag and data_out are held.
  - The matching ack (load_ack for a load, store_ack for a store) sampled high clears the flag and moves to RELEASE.
  - The non-matching ack is ignored.
- RELEASE:
  - Waits for load_req and store_req both low, then goes to IDLE.
  - This prevents a still-held request from retriggering.
- Acks outside DONE are ignored.
- Counter is 4 bits.
- Address bits above DEPTH_LOG2+1 are ignored (wrap-around aliasing) unless checking is compiled in.
- Array contents are not reset.

## Timing

- Reset values: data_out=0, load_completed=0, store_completed=0, busy=0, err=0, state=IDLE, counter=0.
- Reset asserted mid-operation:
  - Immediate return to IDLE with all outputs at their reset values.
  - A store not yet written is discarded; array contents are otherwise untouched.
- Accept edge E0 (request high in IDLE): busy=1 after E0.
- Completion flag rises at edge E0+LATENCY; with LATENCY=1 it rises at E0+1.
- Ack sampled high at edge Ea: flag low after Ea.
- Request low at or before Ea+1: IDLE after Ea+1. The earliest next accept is Ea+2.
- Minimum request-to-request spacing: LATENCY+3 cycles.
- data_out is stable from the completion edge until the next load completes or reset.
- store_completed and load_completed are never high together.

## Configuration

- MEM_ERR_CHECK_EN defined — err is set, sticky until rst, when any of the following occurs at an accept:
  - address_in[1:0] != 0 (block misaligned)
  - any address_in bit above DEPTH_LOG2+1 is set (out of range)
  - load_req and store_req are both high
- The request is still serviced in each error case, with the index truncated and store taking precedence.
- MEM_ERR_CHECK_EN undefined — err is tied to 0 and no checking logic is present.

## Test plan

- Store then load, LATENCY=3:
  - Stimulus: store_req with address 0x0004, data 0xDEAD0100; ack; then load_req at 0x0004.
  - Required: store_completed rises 3 cycles after accept; data_out=0xDEAD0100 with load_completed 3 cycles after load accept.
- Held ack-less completion: load completes and load_ack is held low for 10 cycles -> load_completed and data_out stay constant for all 10 cycles; store_ack pulses during that window are ignored.
- Held request: store_req held high through ack and 4 more cycles -> FSM stays in RELEASE, exactly one write occurs; a new accept happens only after store_req drops.
- Reset mid-store: store at 0x0010, data 0x12345678, over a prior value of 0x0; rst pulsed on the 2nd BUSY cycle -> outputs return to reset values asynchronously; a subsequent load of 0x0010 returns 0x00000000.
- Simultaneous requests: load_req and store_req both high, address 0x0008, data 0xA5A5A5A5 -> store performed, store_completed only; err=1 with MEM_ERR_CHECK_EN, err=0 without it.
- Alias/range with MEM_ERR_CHECK_EN and DEPTH_LOG2=8: store to 0x0404 -> err=1 and the block is written to index 1; a load of 0x0004 returns the stored data.
